// File: rtl/tetris_cmd_scheduler_pkg.sv
// Shared types and default timing constants for the tetris command scheduler.
package tetris_cmd_scheduler_pkg;

  localparam int GRAV_W = 25;

  localparam logic [GRAV_W-1:0] GRAVITY_INIT_DEF = 25'd25_000_000;
  localparam logic [GRAV_W-1:0] GRAVITY_MIN_DEF  = 25'd2_500_000;
  localparam logic [GRAV_W-1:0] SPEEDUP_STEP_DEF = 25'd1_250_000;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    LEFT   = 3'd1,
    RIGHT  = 3'd2,
    ROTATE = 3'd3,
    DOWN   = 3'd4,
    DROP   = 3'd5,
    HOLD   = 3'd6
  } ctrl_type;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    PAUSED = 2'd2,
    OVER   = 2'd3
  } sched_state_type;

  typedef enum logic {
    SRC_USER = 1'b0,
    SRC_GRAV = 1'b1
  } src_type;

  // Compare before subtracting so the period can never wrap below the floor.
  function automatic logic [GRAV_W-1:0] next_period(input logic [GRAV_W-1:0] period,
                                                    input logic [GRAV_W-1:0] min_period,
                                                    input logic [GRAV_W-1:0] step);
    logic [GRAV_W:0] threshold;
    threshold = {1'b0, min_period} + {1'b0, step};
    if ({1'b0, period} >= threshold) return period - step;
    return min_period;
  endfunction

endpackage

// File: rtl/tetris_cmd_scheduler_cmd_fifo.sv
// Small synchronous FIFO for user commands; flush empties it in one cycle.
module tetris_cmd_scheduler_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 3
) (
  input  logic                     clk_50MHz,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             do_push, do_pop;

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is accepted.
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/tetris_cmd_scheduler.sv
// Merges queued user commands with the gravity tick and hands the engine one
// command per ready window; also sequences pause, game-over and speed-up.
module tetris_cmd_scheduler
  import tetris_cmd_scheduler_pkg::*;
#(
  parameter logic [GRAV_W-1:0] GRAVITY_INIT = GRAVITY_INIT_DEF,
  parameter logic [GRAV_W-1:0] GRAVITY_MIN  = GRAVITY_MIN_DEF,
  parameter logic [GRAV_W-1:0] SPEEDUP_STEP = SPEEDUP_STEP_DEF,
  parameter int                FIFO_DEPTH   = 4
) (
  input  logic                         clk_50MHz,
  input  logic                         reset_n,
  input  ctrl_type                     cmd_in_i,
  input  logic                         cmd_valid_i,
  input  logic                         pause_toggle_i,
  input  logic                         speed_up_i,
  input  logic                         game_over_i,
  input  logic                         tetris_ready_i,
  output ctrl_type                     ctrl_out_o,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level_o,
  output logic [7:0]                   drop_cnt_o,
  output logic                         paused_o
);

  sched_state_type   state_q;
  ctrl_type          ctrl_q;
  src_type           last_src_q;
  logic [GRAV_W-1:0] cnt_q, period_q;
  logic              grav_pend_q, wait_q, pause_pend_q;
  logic [7:0]        drop_q;

  logic              fifo_full, fifo_empty;
  logic [2:0]        fifo_dout;
  logic              push_req, drop_push, issue, pick_user, grav_active, pause_exit;
  ctrl_type          issue_cmd;

  assign push_req    = cmd_valid_i && (cmd_in_i != NONE) && (state_q == RUN || state_q == WAIT);
  assign drop_push   = push_req && fifo_full && !(issue && pick_user);
  assign grav_active = (state_q == RUN) || (state_q == WAIT);

  // game_over and pause_toggle both pre-empt an issue in RUN.
  assign issue = (state_q == RUN) && !game_over_i && !pause_toggle_i && tetris_ready_i
               && (!fifo_empty || grav_pend_q);
  assign pick_user = !fifo_empty && (!grav_pend_q || last_src_q == SRC_GRAV);
  assign issue_cmd = pick_user ? ctrl_type'(fifo_dout) : DOWN;
  assign pause_exit = pause_pend_q ^ pause_toggle_i;

  tetris_cmd_scheduler_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (3)
  ) u_cmd_fifo (
    .clk_50MHz (clk_50MHz),
    .reset_n   (reset_n),
    .flush_i   (state_q == OVER),
    .push_i    (push_req),
    .data_i    (cmd_in_i),
    .pop_i     (issue && pick_user),
    .data_o    (fifo_dout),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .level_o   (fifo_level_o)
  );

  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      state_q      <= RUN;
      ctrl_q       <= NONE;
      last_src_q   <= SRC_GRAV;
      cnt_q        <= GRAVITY_INIT;
      period_q     <= GRAVITY_INIT;
      grav_pend_q  <= 1'b0;
      wait_q       <= 1'b0;
      pause_pend_q <= 1'b0;
      drop_q       <= 8'd0;
    end else begin
      ctrl_q <= NONE;

      if (speed_up_i) period_q <= next_period(period_q, GRAVITY_MIN, SPEEDUP_STEP);
      if (drop_push && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;

      if (issue && issue_cmd == DOWN) begin
        cnt_q       <= period_q;
        grav_pend_q <= 1'b0;
      end else if (grav_active) begin
        if (cnt_q <= 25'd1) begin
          cnt_q       <= period_q;
          grav_pend_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 25'd1;
        end
      end

      case (state_q)
        RUN: begin
          if (game_over_i) state_q <= OVER;
          else if (pause_toggle_i) state_q <= PAUSED;
          else if (issue) begin
            ctrl_q       <= issue_cmd;
            last_src_q   <= pick_user ? SRC_USER : SRC_GRAV;
            wait_q       <= 1'b1;
            pause_pend_q <= 1'b0;
            state_q      <= WAIT;
          end
        end
        WAIT: begin
          if (game_over_i) state_q <= OVER;
          else if (wait_q) begin
            wait_q       <= 1'b0;
            pause_pend_q <= pause_exit;
          end else if (tetris_ready_i) begin
            pause_pend_q <= 1'b0;
            state_q      <= pause_exit ? PAUSED : RUN;
          end else begin
            pause_pend_q <= pause_exit;
          end
        end
        PAUSED: begin
          if (game_over_i) state_q <= OVER;
          else if (pause_toggle_i) state_q <= RUN;
        end
        OVER: begin
          grav_pend_q <= 1'b0;
        end
      endcase
    end
  end

  assign ctrl_out_o = ctrl_q;
  assign drop_cnt_o = drop_q;
  assign paused_o   = (state_q == PAUSED);

endmodule

// File: tb/tb_tetris_cmd_scheduler.sv
// Directed bench with a cycle-stamped scoreboard of expected ctrl_out pulses.
module tb_tetris_cmd_scheduler;
  import tetris_cmd_scheduler_pkg::*;

  localparam int INIT = 200;

  logic       clk_50MHz = 1'b0;
  logic       reset_n;
  ctrl_type   cmd_in;
  logic       cmd_valid, pause_toggle, speed_up, game_over, tetris_ready;
  ctrl_type   ctrl_out;
  logic [2:0] fifo_level;
  logic [7:0] drop_cnt;
  logic       paused;

  typedef struct {
    ctrl_type cmd;
    int       at;
  } exp_t;

  exp_t sb[$];
  int   cyc, last_pulse, n_checks, n_pass;

  tetris_cmd_scheduler #(
    .GRAVITY_INIT (25'd200),
    .GRAVITY_MIN  (25'd20),
    .SPEEDUP_STEP (25'd10),
    .FIFO_DEPTH   (4)
  ) dut (
    .clk_50MHz      (clk_50MHz),
    .reset_n        (reset_n),
    .cmd_in_i       (cmd_in),
    .cmd_valid_i    (cmd_valid),
    .pause_toggle_i (pause_toggle),
    .speed_up_i     (speed_up),
    .game_over_i    (game_over),
    .tetris_ready_i (tetris_ready),
    .ctrl_out_o     (ctrl_out),
    .fifo_level_o   (fifo_level),
    .drop_cnt_o     (drop_cnt),
    .paused_o       (paused)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock; sample 1 ns after the edge and score any ctrl_out pulse.
  task automatic tick();
    exp_t e;
    @(posedge clk_50MHz);
    #1;
    cyc++;
    if (ctrl_out !== NONE) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", ctrl_out, NONE);
      end else begin
        e = sb.pop_front();
        chk("pulse_cmd", ctrl_out, e.cmd);
        chk("pulse_cycle", cyc, e.at);
        if (last_pulse >= 0) chk("pulse_gap_ge3", (cyc - last_pulse) >= 3, 1);
        last_pulse = cyc;
      end
    end
  endtask

  task automatic run_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic push(input ctrl_type c);
    cmd_in = c;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic finish_test(input string tag);
    chk({tag, "_sb_drained"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    cmd_in = NONE; cmd_valid = 0; pause_toggle = 0; speed_up = 0;
    game_over = 0; tetris_ready = 0;
    reset_n = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;
    cyc = 0;
    last_pulse = -1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0; n_pass = 0; cyc = 0; last_pulse = -1;

    // 1: reset state, then gravity alone with ready held high
    do_reset();
    chk("rst_ctrl", ctrl_out, NONE);
    chk("rst_level", fifo_level, 0);
    chk("rst_drop", drop_cnt, 0);
    chk("rst_paused", paused, 0);
    tetris_ready = 1;
    sb.push_back('{DOWN, INIT + 1});
    sb.push_back('{DOWN, 2 * INIT + 2});
    run_until(2 * INIT + 10);
    finish_test("t1");

    // 2: three queued commands drain in order once ready rises
    do_reset();
    push(NONE);
    chk("none_ignored_level", fifo_level, 0);
    push(LEFT); push(RIGHT); push(ROTATE);
    chk("t2_level3", fifo_level, 3);
    sb.push_back('{LEFT, 5});
    sb.push_back('{RIGHT, 8});
    sb.push_back('{ROTATE, 11});
    tetris_ready = 1;
    run_until(15);
    chk("t2_level0", fifo_level, 0);
    finish_test("t2");

    // 3: overflow drop counting, push+pop while full, saturation
    do_reset();
    push(LEFT); push(RIGHT); push(ROTATE); push(DOWN); push(DROP); push(HOLD);
    chk("t3_level_full", fifo_level, 4);
    chk("t3_drop2", drop_cnt, 2);
    sb.push_back('{LEFT, 7});
    tetris_ready = 1;
    push(HOLD);
    tetris_ready = 0;
    chk("t3_pushpop_level", fifo_level, 4);
    chk("t3_pushpop_drop", drop_cnt, 2);
    cmd_in = DROP; cmd_valid = 1;
    repeat (300) tick();
    cmd_valid = 0;
    chk("t3_drop_sat", drop_cnt, 255);
    chk("t3_level_after", fifo_level, 4);
    finish_test("t3");

    // 4: both sources pending, last_src=GRAVITY -> RIGHT, DOWN, RIGHT
    do_reset();
    push(RIGHT); push(RIGHT);
    run_until(INIT);
    sb.push_back('{RIGHT, INIT + 1});
    sb.push_back('{DOWN, INIT + 4});
    sb.push_back('{RIGHT, INIT + 7});
    tetris_ready = 1;
    run_until(INIT + 15);
    chk("t4_level0", fifo_level, 0);
    finish_test("t4");

    // 5: pause freezes gravity for 500 cycles
    do_reset();
    tetris_ready = 1;
    run_until(49);
    pause_toggle = 1; tick(); pause_toggle = 0;
    tick();
    chk("t5_paused_hi", paused, 1);
    run_until(100);
    push(LEFT);
    chk("t5_pause_push_level", fifo_level, 0);
    chk("t5_pause_push_drop", drop_cnt, 0);
    run_until(549);
    pause_toggle = 1; tick(); pause_toggle = 0;
    chk("t5_paused_lo", paused, 0);
    sb.push_back('{DOWN, INIT + 1 + 500});
    run_until(INIT + 510);
    finish_test("t5");

    // 6: speed-up, clamp at the floor, then game over from WAIT
    do_reset();
    tetris_ready = 1;
    speed_up = 1; tick(); speed_up = 0;
    sb.push_back('{DOWN, 201});
    sb.push_back('{DOWN, 392});
    run_until(392);
    speed_up = 1; repeat (19) tick(); speed_up = 0;
    sb.push_back('{DOWN, 583});
    sb.push_back('{DOWN, 604});
    run_until(604);
    tetris_ready = 0;
    push(LEFT); push(RIGHT);
    chk("t6_level2", fifo_level, 2);
    game_over = 1;
    tick(); tick();
    chk("t6_over_flush", fifo_level, 0);
    tetris_ready = 1;
    push(LEFT); push(DROP);
    run_until(700);
    chk("t6_over_level", fifo_level, 0);
    chk("t6_over_drop", drop_cnt, 0);
    chk("t6_over_paused", paused, 0);
    game_over = 0;
    run_until(760);
    finish_test("t6");

    do_reset();
    chk("rst2_ctrl", ctrl_out, NONE);
    chk("rst2_level", fifo_level, 0);
    tetris_ready = 1;
    sb.push_back('{DOWN, INIT + 1});
    run_until(INIT + 5);
    finish_test("t6_recover");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
